// File: rtl/hermes_pkg.sv
// Shared definitions for the Hermes local network interface.
package hermes_pkg;
    localparam int FLIT_W = 16;

    localparam int EAST  = 0;
    localparam int WEST  = 1;
    localparam int NORTH = 2;
    localparam int SOUTH = 3;
    localparam int LOCAL = 4;

    typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} inj_state_t;
    typedef enum logic [1:0] {E_HDR, E_SIZE, E_PAYLOAD} ej_state_t;
endpackage

// File: rtl/hermes_ni_fifo.sv
// Eject FIFO: registered storage, head flit visible one edge after it is written.
module hermes_ni_fifo
    import hermes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [FLIT_W-1:0] din,
    output logic [FLIT_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign dout   = r_mem[r_rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; dout is only consumed while the FIFO is non-empty.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end
endmodule

// File: rtl/hermes_local_ni.sv
// Hermes local NI: packetises core beats onto the router LOCAL port and parses ejected packets.
// inject: IDLE | wait for core | HEADER | send target | SIZE | send len | PAYLOAD | forward beats
// eject:  E_HDR | pop/check header | E_SIZE | pop/latch len | E_PAYLOAD | deliver beats
module hermes_local_ni
    import hermes_pkg::*;
#(
    parameter logic [7:0] ADDRESS = 8'h11,
    parameter int         DEPTH   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] in_data,
    input  logic [7:0]        in_target,
    input  logic [15:0]       in_len,
    output logic              tx,
    output logic [FLIT_W-1:0] data_out,
    input  logic              credit_i,
    output logic              clock_tx,
    input  logic              rx,
    input  logic [FLIT_W-1:0] data_in,
    output logic              credit_o,
    input  logic              clock_rx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [15:0]       out_len,
    output logic              err_misroute,
    output logic              err_overflow,
    output logic [15:0]       tx_pkt_count,
    output logic [15:0]       rx_pkt_count
);
    inj_state_t r_inj_state, w_inj_next;
    logic [7:0]  r_target;
    logic [15:0] r_len;
    logic [15:0] r_tx_rem;
    logic        w_tx_xfer;

    ej_state_t r_ej_state, w_ej_next;
    logic [FLIT_W-1:0] w_fifo_dout;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_fifo_pop;
    logic [15:0] r_ej_rem;
    logic        r_first;
    logic        w_unused;

    assign clock_tx  = clock;
    assign w_unused  = clock_rx;
    assign w_tx_xfer = tx && credit_i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_inj_state <= IDLE;
        else        r_inj_state <= w_inj_next;
    end

    always_comb begin
        w_inj_next = r_inj_state;
        case (r_inj_state)
            IDLE:    if (in_valid) w_inj_next = HEADER;
            HEADER:  if (w_tx_xfer) w_inj_next = SIZE;
            SIZE:    if (w_tx_xfer) w_inj_next = (r_len == 16'd0) ? IDLE : PAYLOAD;
            PAYLOAD: if (w_tx_xfer && r_tx_rem == 16'd1) w_inj_next = IDLE;
            default: w_inj_next = IDLE;
        endcase
    end

    always_comb begin
        tx       = 1'b0;
        data_out = '0;
        in_ready = 1'b0;
        case (r_inj_state)
            HEADER: begin
                tx       = 1'b1;
                data_out = {8'h00, r_target};
            end
            SIZE: begin
                tx       = 1'b1;
                data_out = r_len;
            end
            PAYLOAD: begin
                tx       = in_valid;
                data_out = in_data;
                in_ready = credit_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_target     <= '0;
            r_len        <= '0;
            r_tx_rem     <= '0;
            tx_pkt_count <= '0;
        end else begin
            if (r_inj_state == IDLE && in_valid) begin
                r_target <= in_target;
                r_len    <= in_len;
            end
            if (r_inj_state == SIZE && w_tx_xfer) begin
                r_tx_rem <= r_len;
                if (r_len == 16'd0) tx_pkt_count <= tx_pkt_count + 16'd1;
            end
            if (r_inj_state == PAYLOAD && w_tx_xfer) begin
                r_tx_rem <= r_tx_rem - 16'd1;
                if (r_tx_rem == 16'd1) tx_pkt_count <= tx_pkt_count + 16'd1;
            end
        end
    end

    hermes_ni_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx),
        .pop   (w_fifo_pop),
        .din   (data_in),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign credit_o = !w_fifo_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_ej_state <= E_HDR;
        else        r_ej_state <= w_ej_next;
    end

    always_comb begin
        w_ej_next = r_ej_state;
        case (r_ej_state)
            E_HDR:     if (!w_fifo_empty) w_ej_next = E_SIZE;
            E_SIZE:    if (!w_fifo_empty) w_ej_next = (w_fifo_dout == 16'd0) ? E_HDR : E_PAYLOAD;
            E_PAYLOAD: if (w_fifo_pop && r_ej_rem == 16'd1) w_ej_next = E_HDR;
            default:   w_ej_next = E_HDR;
        endcase
    end

    always_comb begin
        out_valid  = 1'b0;
        w_fifo_pop = 1'b0;
        case (r_ej_state)
            E_HDR, E_SIZE: w_fifo_pop = !w_fifo_empty;
            E_PAYLOAD: begin
                out_valid  = !w_fifo_empty;
                w_fifo_pop = !w_fifo_empty && out_ready;
            end
            default: ;
        endcase
        // Gate the head so uninitialised storage never reaches the core.
        out_data = out_valid ? w_fifo_dout : '0;
        out_sop  = out_valid && r_first;
        out_eop  = out_valid && (r_ej_rem == 16'd1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_len      <= '0;
            r_ej_rem     <= '0;
            r_first      <= 1'b0;
            rx_pkt_count <= '0;
            err_misroute <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (rx && w_fifo_full) err_overflow <= 1'b1;
            if (r_ej_state == E_HDR && !w_fifo_empty && w_fifo_dout[7:0] != ADDRESS)
                err_misroute <= 1'b1;
            if (r_ej_state == E_SIZE && !w_fifo_empty) begin
                out_len  <= w_fifo_dout;
                r_ej_rem <= w_fifo_dout;
                r_first  <= 1'b1;
                if (w_fifo_dout == 16'd0) rx_pkt_count <= rx_pkt_count + 16'd1;
            end
            if (r_ej_state == E_PAYLOAD && w_fifo_pop) begin
                r_first  <= 1'b0;
                r_ej_rem <= r_ej_rem - 16'd1;
                if (r_ej_rem == 16'd1) rx_pkt_count <= rx_pkt_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_hermes_local_ni.sv
// Directed bench for hermes_local_ni: inject framing, credit stalls, eject parsing, overflow, reset.
module tb_hermes_local_ni;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic [7:0]  in_target;
    logic [15:0] in_len;
    logic        tx;
    logic [15:0] data_out;
    logic        credit_i, clock_tx;
    logic        rx;
    logic [15:0] data_in;
    logic        credit_o, clock_rx;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        out_sop, out_eop;
    logic [15:0] out_len;
    logic        err_misroute, err_overflow;
    logic [15:0] tx_pkt_count, rx_pkt_count;

    int n_vec = 0;
    int n_err = 0;
    int n_valid_seen = 0;
    logic [33:0] beat_q [$];

    always #5 clock = ~clock;

    hermes_local_ni #(.ADDRESS(8'h11), .DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_target(in_target), .in_len(in_len),
        .tx(tx), .data_out(data_out), .credit_i(credit_i), .clock_tx(clock_tx),
        .rx(rx), .data_in(data_in), .credit_o(credit_o), .clock_rx(clock_rx),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_len(out_len),
        .err_misroute(err_misroute), .err_overflow(err_overflow),
        .tx_pkt_count(tx_pkt_count), .rx_pkt_count(rx_pkt_count)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_flit(input logic [15:0] f);
        @(negedge clock);
        rx      = 1'b1;
        data_in = f;
    endtask

    // Record each accepted eject beat as {sop, eop, len, data}.
    always @(negedge clock) begin
        #2;
        if (out_valid) n_valid_seen++;
        if (out_valid && out_ready) beat_q.push_back({out_sop, out_eop, out_len, out_data});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_valid = 0; in_data = 0; in_target = 0; in_len = 0; credit_i = 0;
        rx = 0; data_in = 0; out_ready = 0; clock_rx = 0;
        reset = 0;

        repeat (2) @(negedge clock);
        #1;
        check_vec("rst_tx", tx, 0);
        check_vec("rst_data_out", data_out, 0);
        check_vec("rst_in_ready", in_ready, 0);
        check_vec("rst_out_valid", out_valid, 0);
        check_vec("rst_sop_eop", {out_sop, out_eop}, 0);
        check_vec("rst_out_data", out_data, 0);
        check_vec("rst_out_len", out_len, 0);
        check_vec("rst_credit_o", credit_o, 1);
        check_vec("rst_counts", {tx_pkt_count, rx_pkt_count}, 0);
        check_vec("rst_errs", {err_misroute, err_overflow}, 0);
        @(negedge clock);
        reset = 1;

        // Inject: target 0x22, len 3, credit held high
        @(negedge clock);
        in_valid = 1; in_target = 8'h22; in_len = 16'd3; in_data = 16'hD000; credit_i = 1;
        #1;
        check_vec("idle_tx", tx, 0);
        check_vec("idle_in_ready", in_ready, 0);
        @(negedge clock); #1;
        check_vec("hdr_tx", tx, 1);
        check_vec("hdr_data", data_out, 16'h0022);
        @(negedge clock); #1;
        check_vec("size_data", data_out, 16'h0003);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_data = 16'hD000 + 16'(i);
            #1;
            check_vec("pay_data", data_out, 16'hD000 + 16'(i));
            check_vec("pay_in_ready", in_ready, 1);
        end
        @(negedge clock);
        in_valid = 0;
        #1;
        check_vec("pkt1_tx_idle", tx, 0);
        check_vec("pkt1_count", tx_pkt_count, 1);

        // Inject with credit stall during SIZE and stalls in PAYLOAD
        @(negedge clock);
        in_valid = 1; in_target = 8'h44; in_len = 16'd3; in_data = 16'hE000;
        @(negedge clock); #1;
        check_vec("hdr2_data", data_out, 16'h0044);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            credit_i = 0;
            #1;
            check_vec("stall_tx", tx, 1);
            check_vec("stall_data", data_out, 16'h0003);
        end
        @(negedge clock);
        credit_i = 1;
        #1;
        check_vec("stall_release", data_out, 16'h0003);
        @(negedge clock);
        in_valid = 0;
        #1;
        check_vec("bubble_tx", tx, 0);
        @(negedge clock);
        in_valid = 1; credit_i = 0;
        #1;
        check_vec("pay_stall_ready", in_ready, 0);
        check_vec("pay_stall_data", data_out, 16'hE000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            credit_i = 1;
            in_data = 16'hE000 + 16'(i);
            #1;
            check_vec("pay2_data", data_out, 16'hE000 + 16'(i));
        end
        @(negedge clock);
        in_valid = 0;
        #1;
        check_vec("pkt2_count", tx_pkt_count, 2);

        // Eject: good 2-flit packet
        beat_q.delete();
        out_ready = 1;
        send_flit(16'h0011);
        send_flit(16'h0002);
        send_flit(16'hAAAA);
        send_flit(16'hBBBB);
        @(negedge clock);
        rx = 0;
        repeat (4) @(negedge clock);
        #3;
        check_vec("ej1_beats", beat_q.size(), 2);
        if (beat_q.size() == 2) begin
            check_vec("ej1_beat0", beat_q[0], {1'b1, 1'b0, 16'd2, 16'hAAAA});
            check_vec("ej1_beat1", beat_q[1], {1'b0, 1'b1, 16'd2, 16'hBBBB});
        end
        check_vec("ej1_misroute", err_misroute, 0);
        check_vec("ej1_rx_count", rx_pkt_count, 1);

        // Eject: FIFO fill with out_ready low, then a forced flit while full
        beat_q.delete();
        out_ready = 0;
        send_flit(16'h0011);
        send_flit(16'h0008);
        @(negedge clock);
        rx = 0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            rx = 1; data_in = 16'hC000 + 16'(i);
            #1;
            check_vec("fill_credit_hi", credit_o, 1);
        end
        @(negedge clock);
        rx = 1; data_in = 16'hC004;
        #1;
        check_vec("full_credit_lo", credit_o, 0);
        check_vec("pre_overflow", err_overflow, 0);
        @(negedge clock);
        rx = 0; out_ready = 1;
        #1;
        check_vec("overflow_set", err_overflow, 1);
        for (int i = 5; i < 9; i++) send_flit(16'hC000 + 16'(i));
        @(negedge clock);
        rx = 0;
        repeat (8) @(negedge clock);
        #3;
        check_vec("ej2_beats", beat_q.size(), 8);
        if (beat_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check_vec("ej2_beat", beat_q[i],
                          {(i == 0), (i == 7), 16'd8, (i < 4) ? 16'hC000 + 16'(i) : 16'hC001 + 16'(i)});
            end
        end
        check_vec("ej2_rx_count", rx_pkt_count, 2);

        // Eject: misrouted zero-length packet
        beat_q.delete();
        n_valid_seen = 0;
        send_flit(16'h0033);
        send_flit(16'h0000);
        @(negedge clock);
        rx = 0;
        repeat (5) @(negedge clock);
        #3;
        check_vec("ej3_no_valid", n_valid_seen, 0);
        check_vec("ej3_misroute", err_misroute, 1);
        check_vec("ej3_rx_count", rx_pkt_count, 3);
        check_vec("ej3_out_len", out_len, 0);

        // Reset mid-PAYLOAD, then a clean packet
        @(negedge clock);
        in_valid = 1; in_target = 8'h66; in_len = 16'd4; in_data = 16'hF000; credit_i = 1;
        repeat (3) @(negedge clock);
        #1;
        check_vec("mid_pay_tx", tx, 1);
        @(negedge clock);
        reset = 0;
        #1;
        check_vec("rst2_tx", tx, 0);
        check_vec("rst2_data_out", data_out, 0);
        check_vec("rst2_in_ready", in_ready, 0);
        check_vec("rst2_counts", {tx_pkt_count, rx_pkt_count}, 0);
        check_vec("rst2_errs", {err_misroute, err_overflow}, 0);
        check_vec("rst2_credit_o", credit_o, 1);
        in_valid = 0;
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        in_valid = 1; in_target = 8'h55; in_len = 16'd1; in_data = 16'hF1F1;
        #1;
        check_vec("post_idle_tx", tx, 0);
        @(negedge clock); #1;
        check_vec("post_hdr", {tx, data_out}, {1'b1, 16'h0055});
        @(negedge clock); #1;
        check_vec("post_size", data_out, 16'h0001);
        @(negedge clock); #1;
        check_vec("post_pay", data_out, 16'hF1F1);
        check_vec("post_in_ready", in_ready, 1);
        @(negedge clock);
        in_valid = 0;
        #1;
        check_vec("post_count", tx_pkt_count, 1);
        check_vec("post_tx_idle", tx, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
